pmips_fetch_stage: RTL and testbench
====================================

Name: pmips_fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for PMIPSL0.
- Holds the PC, drives the instruction-memory address, and latches the fetched 16-bit instruction into IF/ID.
- Presents `opcode` to the Control block and honours Control's `PCStall` plus the branch redirect (`pc_src`/`branch_target`) from EX.
- A small FSM handles post-reset fill, normal run and halt.

Parameters:
- PC_WIDTH, 8, PC/instruction-address width in words.
- INSTR_WIDTH, 16, instruction width; opcode is bits [INSTR_WIDTH-1 -: 3].
- RESET_PC, 0, PC value loaded on reset.
- HALT_OP, 7, opcode that freezes fetch.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc_stall  in  1  Control's PCStall; holds PC and IF/ID.
- pc_src  in  1  branch taken; redirects PC.
- branch_target  in  PC_WIDTH  redirect address.
- imem_addr  out  PC_WIDTH  instruction-memory address (= pc, combinational).
- imem_data  in  INSTR_WIDTH  instruction word; combinational read, valid in the same cycle.
- ifid_instr  out  INSTR_WIDTH  IF/ID instruction.
- ifid_pc_plus1  out  PC_WIDTH  IF/ID PC+1, for branch target computation.
- ifid_valid  out  1  IF/ID holds a real instruction.
- opcode  out  3  ifid_instr[15:13]; feeds Control.
- pc  out  PC_WIDTH  current PC.
- halted  out  1  high in S_HALT.
- fetch_count  out  16  number of valid instructions latched, saturating.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC, ifid_instr=NOP (all zeros), ifid_pc_plus1=0, ifid_valid=0.
  - fetch_count=0, halted=0, state=S_FILL.
- FSM states: S_FILL, S_RUN, S_HALT.
- S_FILL: exactly 1 cycle after reset release. No fetch; PC and IF/ID hold; pc_src and pc_stall are ignored. Next state is S_RUN.
- S_RUN, at each edge, with priority redirect > stall > advance:
  - Redirect (pc_src=1): pc<=branch_target, ifid_instr<=NOP, ifid_valid<=0; stay in S_RUN. Redirect wins over a simultaneous pc_stall.
  - Stall (pc_stall=1, pc_src=0): pc, IF/ID and fetch_count all hold.
  - Advance:
    - pc<=pc+1, wrapping modulo 2^PC_WIDTH (0xFF -> 0x00, no flag).
    - ifid_instr<=imem_data, ifid_pc_plus1<=pc+1, ifid_valid<=1.
    - fetch_count<=fetch_count+1, saturating at 0xFFFF.
    - If imem_data opcode == HALT_OP: the instruction is still latched and counted, pc<=pc+1 as normal, and the next state is S_HALT.
- S_HALT: halted=1; pc holds.
  - pc_src=1: redirect exactly as in S_RUN, then go to S_RUN with halted=0 next cycle. This squashes a halt fetched behind a taken branch.
  - pc_stall=1 (no redirect): IF/ID holds.
  - Otherwise: ifid_instr<=NOP, ifid_valid<=0, fetch_count holds.
  - Leave S_HALT only by redirect or reset.
- Latency: the instruction at address A appears on ifid_instr the edge after imem_addr=A. Redirect-to-target fetch costs 1 bubble.
- Reset asserted mid-operation: all state clears immediately (asynchronously), regardless of state or inputs.
- opcode is purely combinational from ifid_instr, so it equals 0 (R-type) while IF/ID holds NOP.

Decomposition:
- Shared package pmips_pkg holds:
  - opcode constants OP_RTYPE=0, OP_BEQ=2, OP_ADDI=3, OP_HALT=7;
  - NOP instruction constant;
  - fetch FSM state encoding (S_FILL, S_RUN, S_HALT).
- One natural sub-module: pmips_ifid_reg, the IF/ID register with load, hold (stall) and flush-to-NOP inputs, with async active-low reset.
- PC register, FSM and counter stay in pmips_fetch_stage.

Test Plan:
- Reset then free run, imem[i] = {3'd3, i[12:0]}:
  - S_FILL lasts 1 cycle with ifid_valid=0.
  - Then ifid_instr = 0x6000, 0x6001, 0x6002 on successive edges; opcode=3; fetch_count 1,2,3.
- Hold pc_stall=1 for 3 cycles at pc=5: pc stays 5, IF/ID and fetch_count frozen. After release, the next edge latches imem[5] and pc=6.
- Assert pc_src=1 with branch_target=0x20 and pc_stall=1 in the same cycle:
  - redirect wins: pc=0x20, ifid_instr=0x0000, ifid_valid=0;
  - the following edge latches imem[0x20].
- Place opcode 7 at address 4:
  - after it latches, halted=1, pc=5 frozen, IF/ID becomes NOP/valid=0;
  - pc_src=1 with target 2 resumes fetch at 2 and clears halted.
- Preload pc near 0xFF via redirect to 0xFE and run: pc goes 0xFF -> 0x00, ifid_pc_plus1=0x00 for the word at 0xFF.
- Drop reset to 0 mid-run (not on a clock edge): all outputs clear immediately. After release, S_FILL repeats with fetch_count=0.

Source files
------------

// File: rtl/pmips_pkg.sv
// Shared PMIPSL0 definitions: opcode values, the NOP word and the fetch FSM states.
package pmips_pkg;

   localparam int unsigned OPCODE_W = 3;
   localparam int unsigned INSTR_W  = 16;
   localparam int unsigned PC_W     = 8;
   localparam int unsigned COUNT_W  = 16;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = 3'd0;
   localparam logic [OPCODE_W-1:0] OP_BEQ   = 3'd2;
   localparam logic [OPCODE_W-1:0] OP_ADDI  = 3'd3;
   localparam logic [OPCODE_W-1:0] OP_HALT  = 3'd7;

   // An all-zero word decodes as a harmless R-type no-op.
   localparam logic [INSTR_W-1:0] NOP = '0;

   typedef enum logic [1:0] {
      S_FILL = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/pmips_ifid_reg.sv
// IF/ID pipeline register: flush to NOP beats hold, hold beats load.
module pmips_ifid_reg
   import pmips_pkg::*;
#(
   parameter int unsigned PC_WIDTH    = 8,
   parameter int unsigned INSTR_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   load,
   input  logic                   hold,
   input  logic                   flush,
   input  logic [INSTR_WIDTH-1:0] instr_in,
   input  logic [PC_WIDTH-1:0]    pc_plus1_in,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [PC_WIDTH-1:0]    pc_plus1,
   output logic                   valid
);

   // pc_plus1 is left alone on a flush; only a real load updates it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         instr    <= INSTR_WIDTH'(NOP);
         pc_plus1 <= '0;
         valid    <= 1'b0;
      end else if (flush) begin
         instr    <= INSTR_WIDTH'(NOP);
         valid    <= 1'b0;
      end else if (load && !hold) begin
         instr    <= instr_in;
         pc_plus1 <= pc_plus1_in;
         valid    <= 1'b1;
      end
   end

endmodule

// File: rtl/pmips_fetch_stage.sv
// PMIPSL0 instruction fetch: PC register, fill/run/halt FSM, fetch counter and IF/ID.
module pmips_fetch_stage
   import pmips_pkg::*;
#(
   parameter int unsigned PC_WIDTH    = 8,
   parameter int unsigned INSTR_WIDTH = 16,
   parameter int unsigned RESET_PC    = 0,
   parameter int unsigned HALT_OP     = 7
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   pc_stall,
   input  logic                   pc_src,
   input  logic [PC_WIDTH-1:0]    branch_target,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic [INSTR_WIDTH-1:0] imem_data,
   output logic [INSTR_WIDTH-1:0] ifid_instr,
   output logic [PC_WIDTH-1:0]    ifid_pc_plus1,
   output logic                   ifid_valid,
   output logic [OPCODE_W-1:0]    opcode,
   output logic [PC_WIDTH-1:0]    pc,
   output logic                   halted,
   output logic [COUNT_W-1:0]     fetch_count
);

   fetch_state_t          state;
   fetch_state_t          state_next;
   logic [PC_WIDTH-1:0]   pc_next;
   logic [PC_WIDTH-1:0]   pc_inc;
   logic [OPCODE_W-1:0]   fetch_opcode;
   logic                  ifid_load;
   logic                  ifid_hold;
   logic                  ifid_flush;
   logic                  count_inc;

   assign imem_addr    = pc;
   assign pc_inc       = pc + PC_WIDTH'(1);
   assign fetch_opcode = imem_data[INSTR_WIDTH-1 -: OPCODE_W];
   assign opcode       = ifid_instr[INSTR_WIDTH-1 -: OPCODE_W];

   // State, PC, halt flag and saturating fetch counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= S_FILL;
         pc          <= PC_WIDTH'(RESET_PC);
         halted      <= 1'b0;
         fetch_count <= '0;
      end else begin
         state  <= state_next;
         pc     <= pc_next;
         halted <= (state_next == S_HALT);
         if (count_inc && (fetch_count != {COUNT_W{1'b1}})) begin
            fetch_count <= fetch_count + COUNT_W'(1);
         end
      end
   end

   // Next state and IF/ID control; redirect > stall > advance in RUN and HALT.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      ifid_load  = 1'b0;
      ifid_hold  = 1'b0;
      ifid_flush = 1'b0;
      count_inc  = 1'b0;
      case (state)
         S_FILL: begin
            state_next = S_RUN;
         end
         S_RUN: begin
            if (pc_src) begin
               pc_next    = branch_target;
               ifid_flush = 1'b1;
            end else if (pc_stall) begin
               ifid_hold = 1'b1;
            end else begin
               pc_next   = pc_inc;
               ifid_load = 1'b1;
               count_inc = 1'b1;
               if (fetch_opcode == OPCODE_W'(HALT_OP)) begin
                  state_next = S_HALT;
               end
            end
         end
         S_HALT: begin
            // A taken branch squashes the halt that was fetched behind it.
            if (pc_src) begin
               pc_next    = branch_target;
               ifid_flush = 1'b1;
               state_next = S_RUN;
            end else if (pc_stall) begin
               ifid_hold = 1'b1;
            end else begin
               ifid_flush = 1'b1;
            end
         end
         default: begin
            state_next = S_FILL;
         end
      endcase
   end

   pmips_ifid_reg #(
      .PC_WIDTH    (PC_WIDTH),
      .INSTR_WIDTH (INSTR_WIDTH)
   ) u_ifid (
      .clock       (clock),
      .reset       (reset),
      .load        (ifid_load),
      .hold        (ifid_hold),
      .flush       (ifid_flush),
      .instr_in    (imem_data),
      .pc_plus1_in (pc_inc),
      .instr       (ifid_instr),
      .pc_plus1    (ifid_pc_plus1),
      .valid       (ifid_valid)
   );

endmodule

// File: tb/tb_pmips_fetch_stage.sv
// Bench for pmips_fetch_stage: directed vector tables, async-reset sequences and random run vs a model.
module tb_pmips_fetch_stage;

   logic        clock;
   logic        reset;
   logic        pc_stall;
   logic        pc_src;
   logic [7:0]  branch_target;
   logic [7:0]  imem_addr;
   logic [15:0] imem_data;
   logic [15:0] ifid_instr;
   logic [7:0]  ifid_pc_plus1;
   logic        ifid_valid;
   logic [2:0]  opcode;
   logic [7:0]  pc;
   logic        halted;
   logic [15:0] fetch_count;

   logic [15:0] imem [256];
   assign imem_data = imem[imem_addr];

   pmips_fetch_stage dut (
      .clock         (clock),
      .reset         (reset),
      .pc_stall      (pc_stall),
      .pc_src        (pc_src),
      .branch_target (branch_target),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .ifid_instr    (ifid_instr),
      .ifid_pc_plus1 (ifid_pc_plus1),
      .ifid_valid    (ifid_valid),
      .opcode        (opcode),
      .pc            (pc),
      .halted        (halted),
      .fetch_count   (fetch_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;

   // Behavioural model of the fetch stage, in terms of the architectural rules.
   int  m_pc, m_pc1, m_count;
   logic [15:0] m_instr;
   bit  m_valid, m_fill, m_halt;

   function automatic void model_reset();
      m_pc = 0; m_pc1 = 0; m_count = 0; m_instr = 16'h0;
      m_valid = 0; m_fill = 1; m_halt = 0;
   endfunction

   function automatic void model_step(input bit s, input bit r, input int t);
      logic [15:0] w;
      if (m_fill) begin
         m_fill = 0;
         return;
      end
      if (r) begin
         m_pc = t; m_instr = 16'h0; m_valid = 0; m_halt = 0;
         return;
      end
      if (s) return;
      if (m_halt) begin
         m_instr = 16'h0; m_valid = 0;
         return;
      end
      w = imem[m_pc];
      m_instr = w;
      m_pc1   = (m_pc + 1) % 256;
      m_pc    = m_pc1;
      m_valid = 1;
      if (m_count < 65535) m_count = m_count + 1;
      if (w[15:13] == 3'd7) m_halt = 1;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      cmp("model pc", 32'(pc), 32'(m_pc));
      cmp("model imem_addr", 32'(imem_addr), 32'(m_pc));
      cmp("model ifid_instr", 32'(ifid_instr), 32'(m_instr));
      cmp("model ifid_pc_plus1", 32'(ifid_pc_plus1), 32'(m_pc1));
      cmp("model ifid_valid", 32'(ifid_valid), 32'(m_valid));
      cmp("model opcode", 32'(opcode), 32'(m_instr[15:13]));
      cmp("model fetch_count", 32'(fetch_count), 32'(m_count));
      cmp("model halted", 32'(halted), 32'(m_halt));
   endtask

   task automatic check_cleared(input string tag);
      cmp({tag, " pc"}, 32'(pc), 32'h0);
      cmp({tag, " ifid_instr"}, 32'(ifid_instr), 32'h0);
      cmp({tag, " ifid_pc_plus1"}, 32'(ifid_pc_plus1), 32'h0);
      cmp({tag, " ifid_valid"}, 32'(ifid_valid), 32'h0);
      cmp({tag, " opcode"}, 32'(opcode), 32'h0);
      cmp({tag, " fetch_count"}, 32'(fetch_count), 32'h0);
      cmp({tag, " halted"}, 32'(halted), 32'h0);
   endtask

   // One clock: drive on the falling edge, step the model at the rising edge, sample 1 ns later.
   task automatic cyc(input bit s, input bit r, input logic [7:0] t);
      @(negedge clock);
      pc_stall = s; pc_src = r; branch_target = t;
      @(posedge clock);
      model_step(s, r, int'(t));
      #1;
      check_model();
   endtask

   typedef struct {
      bit          stall;
      bit          src;
      logic [7:0]  tgt;
      logic [7:0]  pc;
      logic [15:0] instr;
      logic [7:0]  pc1;
      bit          valid;
      logic [15:0] count;
      bit          halted;
   } vec_t;

   vec_t tab[$];

   function automatic vec_t mk(input bit s, input bit r, input logic [7:0] t, input logic [7:0] p,
                               input logic [15:0] i, input logic [7:0] p1, input bit v,
                               input logic [15:0] c, input bit h);
      vec_t x;
      x.stall = s; x.src = r; x.tgt = t; x.pc = p; x.instr = i;
      x.pc1 = p1; x.valid = v; x.count = c; x.halted = h;
      return x;
   endfunction

   task automatic run_table(input string tag);
      logic [15:0] ei;
      foreach (tab[k]) begin
         cyc(tab[k].stall, tab[k].src, tab[k].tgt);
         ei = tab[k].instr;
         cmp($sformatf("%s[%0d] pc", tag, k), 32'(pc), 32'(tab[k].pc));
         cmp($sformatf("%s[%0d] ifid_instr", tag, k), 32'(ifid_instr), 32'(ei));
         cmp($sformatf("%s[%0d] ifid_pc_plus1", tag, k), 32'(ifid_pc_plus1), 32'(tab[k].pc1));
         cmp($sformatf("%s[%0d] ifid_valid", tag, k), 32'(ifid_valid), 32'(tab[k].valid));
         cmp($sformatf("%s[%0d] opcode", tag, k), 32'(opcode), 32'(ei[15:13]));
         cmp($sformatf("%s[%0d] fetch_count", tag, k), 32'(fetch_count), 32'(tab[k].count));
         cmp($sformatf("%s[%0d] halted", tag, k), 32'(halted), 32'(tab[k].halted));
      end
      tab.delete();
   endtask

   // Pull reset low between edges, confirm everything clears at once, hold a cycle, release.
   task automatic async_reset(input string tag);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check_cleared(tag);
      @(posedge clock);
      #1;
      check_cleared({tag, " held"});
      reset = 1'b1;
   endtask

   initial begin
      logic [12:0] lo;
      reset = 1'b0; pc_stall = 1'b0; pc_src = 1'b0; branch_target = 8'h0;
      for (int i = 0; i < 256; i++) begin
         lo = 13'(i);
         imem[i] = {3'd3, lo};
      end
      model_reset();
      #2;
      check_cleared("reset");
      @(posedge clock);
      #1;
      reset = 1'b1;

      // Free run, stall, redirect-over-stall, PC wrap.
      tab.push_back(mk(0, 0, 8'h00, 8'h00, 16'h0000, 8'h00, 0, 16'd0, 0));
      tab.push_back(mk(0, 0, 8'h00, 8'h01, 16'h6000, 8'h01, 1, 16'd1, 0));
      tab.push_back(mk(0, 0, 8'h00, 8'h02, 16'h6001, 8'h02, 1, 16'd2, 0));
      tab.push_back(mk(0, 0, 8'h00, 8'h03, 16'h6002, 8'h03, 1, 16'd3, 0));
      tab.push_back(mk(0, 0, 8'h00, 8'h04, 16'h6003, 8'h04, 1, 16'd4, 0));
      tab.push_back(mk(0, 0, 8'h00, 8'h05, 16'h6004, 8'h05, 1, 16'd5, 0));
      tab.push_back(mk(1, 0, 8'h00, 8'h05, 16'h6004, 8'h05, 1, 16'd5, 0));
      tab.push_back(mk(1, 0, 8'h00, 8'h05, 16'h6004, 8'h05, 1, 16'd5, 0));
      tab.push_back(mk(1, 0, 8'h00, 8'h05, 16'h6004, 8'h05, 1, 16'd5, 0));
      tab.push_back(mk(0, 0, 8'h00, 8'h06, 16'h6005, 8'h06, 1, 16'd6, 0));
      tab.push_back(mk(1, 1, 8'h20, 8'h20, 16'h0000, 8'h06, 0, 16'd6, 0));
      tab.push_back(mk(0, 0, 8'h00, 8'h21, 16'h6020, 8'h21, 1, 16'd7, 0));
      tab.push_back(mk(0, 1, 8'hFE, 8'hFE, 16'h0000, 8'h21, 0, 16'd7, 0));
      tab.push_back(mk(0, 0, 8'h00, 8'hFF, 16'h60FE, 8'hFF, 1, 16'd8, 0));
      tab.push_back(mk(0, 0, 8'h00, 8'h00, 16'h60FF, 8'h00, 1, 16'd9, 0));
      tab.push_back(mk(0, 0, 8'h00, 8'h01, 16'h6000, 8'h01, 1, 16'd10, 0));
      run_table("run");

      imem[4] = 16'hE004;
      async_reset("midrun");

      // Fill ignores redirect; halt entry, stall/idle in halt, resume by branch.
      tab.push_back(mk(1, 1, 8'h33, 8'h00, 16'h0000, 8'h00, 0, 16'd0, 0));
      tab.push_back(mk(0, 0, 8'h00, 8'h01, 16'h6000, 8'h01, 1, 16'd1, 0));
      tab.push_back(mk(0, 0, 8'h00, 8'h02, 16'h6001, 8'h02, 1, 16'd2, 0));
      tab.push_back(mk(0, 0, 8'h00, 8'h03, 16'h6002, 8'h03, 1, 16'd3, 0));
      tab.push_back(mk(0, 0, 8'h00, 8'h04, 16'h6003, 8'h04, 1, 16'd4, 0));
      tab.push_back(mk(0, 0, 8'h00, 8'h05, 16'hE004, 8'h05, 1, 16'd5, 1));
      tab.push_back(mk(0, 0, 8'h00, 8'h05, 16'h0000, 8'h05, 0, 16'd5, 1));
      tab.push_back(mk(1, 0, 8'h00, 8'h05, 16'h0000, 8'h05, 0, 16'd5, 1));
      tab.push_back(mk(0, 1, 8'h02, 8'h02, 16'h0000, 8'h05, 0, 16'd5, 0));
      tab.push_back(mk(0, 0, 8'h00, 8'h03, 16'h6002, 8'h03, 1, 16'd6, 0));
      tab.push_back(mk(0, 0, 8'h00, 8'h04, 16'h6003, 8'h04, 1, 16'd7, 0));
      tab.push_back(mk(0, 0, 8'h00, 8'h05, 16'hE004, 8'h05, 1, 16'd8, 1));
      tab.push_back(mk(1, 0, 8'h00, 8'h05, 16'hE004, 8'h05, 1, 16'd8, 1));
      tab.push_back(mk(0, 0, 8'h00, 8'h05, 16'h0000, 8'h05, 0, 16'd8, 1));
      tab.push_back(mk(1, 1, 8'h10, 8'h10, 16'h0000, 8'h05, 0, 16'd8, 0));
      tab.push_back(mk(0, 0, 8'h00, 8'h11, 16'h6010, 8'h11, 1, 16'd9, 0));
      run_table("halt");

      // Random program and control inputs against the model, with occasional async resets.
      for (int i = 0; i < 256; i++) imem[i] = 16'($urandom);
      async_reset("rand");
      for (int n = 0; n < 3000; n++) begin
         cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, 8'($urandom));
         if ((n % 700) == 699) async_reset("rand mid");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
